// File: rtl/clock_rate_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_ctrl_pkg
// Purpose  : Shared types and constants for the clock rate controller:
//            controller state encoding and the smallest legal divisor.
// Revision : 1.0  initial release
// ============================================================================
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ctrl_state_t;

    // A period needs at least one high and one low cycle.
    localparam int MIN_DIVISOR = 2;

endpackage
`default_nettype wire

// File: rtl/clock_rate_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_rate_controller_if
// Purpose  : Control/config/status bundle of the clock rate controller.
// Ports    : start, stop            run sequencing (level sampled)
//            cfg_valid/cfg_ready    config handshake
//            cfg_divisor, cfg_burst new rate and burst length
//            busy, clock_out, tick, done, periods_left   status outputs
//            master = control logic side, slave = controller side
// Revision : 1.0  initial release
// ============================================================================
interface clock_rate_controller_if #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
);
    logic               start;
    logic               stop;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_divisor;
    logic [BURST_W-1:0] cfg_burst;
    logic               busy;
    logic               clock_out;
    logic               tick;
    logic               done;
    logic [BURST_W-1:0] periods_left;

    modport master (
        output start, stop, cfg_valid, cfg_divisor, cfg_burst,
        input  cfg_ready, busy, clock_out, tick, done, periods_left
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_divisor, cfg_burst,
        output cfg_ready, busy, clock_out, tick, done, periods_left
    );
endinterface
`default_nettype wire

// File: rtl/clock_rate_controller_period_counter.sv
`default_nettype none
// ============================================================================
// Module   : period_counter
// Purpose  : Period counter for the divided clock. Counts 0..D-1 and produces
//            registered clock_out (high for the first floor(D/2) cycles) and
//            tick (last cycle of the period).
// Ports    : clk, reset_n      clock, synchronous active-low reset
//            active            controller is running in the current cycle
//            run_next          controller runs in the next cycle
//            divisor_next      divisor in effect for the next cycle
//            clock_out, tick   registered outputs
//            wrap              current cycle is the last of its period
// Revision : 1.0  initial release
// ============================================================================
module period_counter #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             active,
    input  wire logic             run_next,
    input  wire logic [CNT_W-1:0] divisor_next,
    output logic                  clock_out,
    output logic                  tick,
    output logic                  wrap
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_clock_out;
    logic             r_tick;

    // Counter restarts at 0 on a fresh start, after a tick, and while idle.
    always_comb begin
        w_count_next = '0;
        if (run_next && active && !r_tick) begin
            w_count_next = r_count + CNT_W'(1);
        end
    end

    // Outputs are computed from the next count so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_clock_out <= run_next && (w_count_next < (divisor_next >> 1));
            r_tick      <= run_next && (w_count_next == (divisor_next - CNT_W'(1)));
        end
    end

    assign clock_out = r_clock_out;
    assign tick      = r_tick;
    assign wrap      = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_rate_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_rate_controller
// Purpose  : Run-time controller for a divided clock. Holds the active
//            divisor/burst, accepts new settings over a valid/ready port and
//            applies them only at period boundaries; runs continuously or for
//            N periods with start/stop sequencing.
// Ports    : clock_50MHz   system clock
//            reset_n       synchronous active-low reset
//            ctrl          clock_rate_controller_if.slave bundle
// Revision : 1.0  initial release
// ============================================================================
module clock_rate_controller
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_FREQ = 1,
    parameter int CNT_W        = 32,
    parameter int BURST_W      = 16
) (
    input wire logic               clock_50MHz,
    input wire logic               reset_n,
    clock_rate_controller_if.slave ctrl
);

    localparam int               c_reset_raw = CLK_FREQ / DEFAULT_FREQ;
    localparam logic [CNT_W-1:0] c_min_div   = CNT_W'(MIN_DIVISOR);
    localparam logic [CNT_W-1:0] c_reset_div =
        (c_reset_raw < MIN_DIVISOR) ? c_min_div : CNT_W'(c_reset_raw);

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_next;
    logic [CNT_W-1:0]   r_active_div;
    logic [CNT_W-1:0]   r_shadow_div;
    logic [CNT_W-1:0]   w_cfg_div;
    logic [CNT_W-1:0]   w_div_next;
    logic [BURST_W-1:0] r_active_burst;
    logic [BURST_W-1:0] r_shadow_burst;
    logic [BURST_W-1:0] w_burst_start;
    logic [BURST_W-1:0] r_periods_left;
    logic               r_pending;
    logic               r_cfg_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_wrap;
    logic               w_reload;
    logic               w_last_period;
    logic               w_done_next;
    logic               w_active;
    logic               w_run_next;
    logic               w_clock_out;
    logic               w_tick;

    assign w_accept      = ctrl.cfg_valid && r_cfg_ready;
    assign w_reload      = w_wrap && r_pending;
    assign w_last_period = (r_periods_left == BURST_W'(1));
    assign w_cfg_div     = (ctrl.cfg_divisor < c_min_div) ? c_min_div : ctrl.cfg_divisor;
    // A config accepted on the start edge takes effect for that very run.
    assign w_burst_start = w_accept ? ctrl.cfg_burst : r_active_burst;
    assign w_active      = (r_state != IDLE);
    assign w_run_next    = (w_state_next != IDLE);

    always_comb begin
        w_div_next = r_active_div;
        if ((r_state == IDLE) && w_accept) begin
            w_div_next = w_cfg_div;
        end else if (w_reload) begin
            w_div_next = r_shadow_div;
        end
    end

    // Burst completion takes priority over a stop seen on the same tick.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ctrl.start && !ctrl.stop) w_state_next = RUN;
            end
            RUN: begin
                if (w_wrap) begin
                    if (w_last_period) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else if (ctrl.stop) begin
                        w_state_next = IDLE;
                    end
                end else if (ctrl.stop) begin
                    w_state_next = STOPPING;
                end
            end
            STOPPING: begin
                if (w_wrap) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_50MHz) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_pending      <= 1'b0;
            r_active_div   <= c_reset_div;
            r_active_burst <= '0;
            r_shadow_div   <= c_reset_div;
            r_shadow_burst <= '0;
            r_periods_left <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_run_next;
            r_done  <= w_done_next;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_active_div   <= w_cfg_div;
                    r_active_burst <= ctrl.cfg_burst;
                end
                r_cfg_ready    <= 1'b1;
                r_periods_left <= w_run_next ? w_burst_start : '0;
            end else begin
                if (w_reload) begin
                    r_active_div   <= r_shadow_div;
                    r_active_burst <= r_shadow_burst;
                    r_pending      <= 1'b0;
                    r_cfg_ready    <= 1'b1;
                end else if (w_accept) begin
                    // Accepted on the final edge of a run: nothing left to
                    // defer to, so it lands in the active registers directly.
                    if (!w_run_next) begin
                        r_active_div   <= w_cfg_div;
                        r_active_burst <= ctrl.cfg_burst;
                    end else begin
                        r_shadow_div   <= w_cfg_div;
                        r_shadow_burst <= ctrl.cfg_burst;
                        r_pending      <= 1'b1;
                        r_cfg_ready    <= 1'b0;
                    end
                end
                if (!w_run_next) begin
                    r_periods_left <= '0;
                end else if (w_reload) begin
                    r_periods_left <= r_shadow_burst;
                end else if (w_wrap && (r_periods_left != '0)) begin
                    r_periods_left <= r_periods_left - BURST_W'(1);
                end
            end
        end
    end

    period_counter #(
        .CNT_W (CNT_W)
    ) u_period_counter (
        .clk          (clock_50MHz),
        .reset_n      (reset_n),
        .active       (w_active),
        .run_next     (w_run_next),
        .divisor_next (w_div_next),
        .clock_out    (w_clock_out),
        .tick         (w_tick),
        .wrap         (w_wrap)
    );

    assign ctrl.cfg_ready    = r_cfg_ready;
    assign ctrl.busy         = r_busy;
    assign ctrl.clock_out    = w_clock_out;
    assign ctrl.tick         = w_tick;
    assign ctrl.done         = r_done;
    assign ctrl.periods_left = r_periods_left;

endmodule
`default_nettype wire

// File: tb/tb_clock_rate_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_rate_controller
// Purpose  : Self-checking bench for clock_rate_controller (default D = 4).
//            Directed scenarios plus randomized traffic compared against a
//            period-position model of the controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_rate_controller;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;
    localparam int DEF_D   = 4;

    logic clock_50MHz = 1'b0;
    logic reset_n;

    clock_rate_controller_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    clock_rate_controller #(
        .CLK_FREQ     (50_000_000),
        .DEFAULT_FREQ (12_500_000),
        .CNT_W        (CNT_W),
        .BURST_W      (BURST_W)
    ) dut (
        .clock_50MHz (clock_50MHz),
        .reset_n     (reset_n),
        .ctrl        (bus)
    );

    always #5 clock_50MHz = ~clock_50MHz;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: position within the current period plus the run settings.
    bit m_run, m_stopping, m_pending, m_done;
    int m_pos, m_div, m_burst, m_left, m_sh_div, m_sh_burst;

    localparam logic [BURST_W+4:0] RESET_BUNDLE = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    function automatic int clampd(logic [CNT_W-1:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    task automatic model_reset();
        m_run = 0; m_stopping = 0; m_pending = 0; m_done = 0;
        m_pos = 0; m_div = DEF_D; m_burst = 0; m_left = 0;
        m_sh_div = DEF_D; m_sh_burst = 0;
    endtask

    task automatic model_edge();
        bit acc, finish;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc    = bus.cfg_valid && !m_pending;
        m_done = 0;
        if (!m_run) begin
            if (acc) begin
                m_div   = clampd(bus.cfg_divisor);
                m_burst = int'(bus.cfg_burst);
            end
            if (bus.start && !bus.stop) begin
                m_run = 1; m_pos = 0; m_left = m_burst;
            end
        end else begin
            if (m_pos == m_div - 1) begin
                finish = !m_stopping && (m_left == 1);
                if (m_pending) begin
                    m_div = m_sh_div; m_burst = m_sh_burst; m_left = m_sh_burst;
                    m_pending = 0;
                end else if (m_left > 0) begin
                    m_left--;
                end
                m_pos = 0;
                if (finish) begin
                    m_run = 0; m_done = 1;
                end else if (m_stopping || bus.stop) begin
                    m_run = 0;
                end
            end else begin
                m_pos++;
                if (bus.stop) m_stopping = 1;
            end
            if (acc) begin
                if (m_run) begin
                    m_sh_div = clampd(bus.cfg_divisor);
                    m_sh_burst = int'(bus.cfg_burst);
                    m_pending = 1;
                end else begin
                    m_div = clampd(bus.cfg_divisor);
                    m_burst = int'(bus.cfg_burst);
                end
            end
            if (!m_run) begin
                m_stopping = 0; m_left = 0;
            end
        end
    endtask

    function automatic logic [BURST_W+4:0] model_bundle();
        logic exp_clk, exp_tick;
        exp_clk  = m_run && (m_pos < m_div / 2);
        exp_tick = m_run && (m_pos == m_div - 1);
        return {!m_pending, m_run, exp_clk, exp_tick, m_done, BURST_W'(m_left)};
    endfunction

    function automatic logic [BURST_W+4:0] dut_bundle();
        return {bus.cfg_ready, bus.busy, bus.clock_out, bus.tick, bus.done, bus.periods_left};
    endfunction

    task automatic step();
        @(posedge clock_50MHz);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.stop = 0; bus.cfg_valid = 0;
        bus.cfg_divisor = '0; bus.cfg_burst = '0;
    endtask

    task automatic go_idle();
        reset_n = 0; idle_inputs(); step(); reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0; idle_inputs(); step(); step();
        tests_run++;
        if (dut_bundle() !== RESET_BUNDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h", dut_bundle(), RESET_BUNDLE);
        end
        reset_n = 1;
    endtask

    task automatic test_continuous();
        logic [7:0] pat = 8'b0011_0011;
        go_idle();
        bus.start = 1; step(); bus.start = 0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ({bus.clock_out, bus.tick, bus.busy} !== {pat[i], (i % 4 == 3), 1'b1}) begin
                tests_failed++;
                $display("FAIL continuous_c%0d: clk/tick/busy got %b%b%b want %b%b1", i + 1,
                         bus.clock_out, bus.tick, bus.busy, pat[i], (i % 4 == 3));
            end
            tests_run++;
            if (dut_bundle() !== model_bundle()) begin
                tests_failed++;
                $display("FAIL continuous_model c%0d: got %h want %h", i + 1, dut_bundle(), model_bundle());
            end
            step();
        end
    endtask

    task automatic test_burst();
        int ticks = 0, highs = 0, dones = 0;
        bit prev_tick = 0, done_ok = 0;
        go_idle();
        bus.cfg_valid = 1; bus.cfg_divisor = 5; bus.cfg_burst = 3; step();
        bus.cfg_valid = 0;
        tests_run++;
        if (bus.cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_idle_ready: got %b want 1", bus.cfg_ready);
        end
        bus.start = 1; step(); bus.start = 0;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (dut_bundle() !== model_bundle()) begin
                tests_failed++;
                $display("FAIL burst_model c%0d: got %h want %h", i + 1, dut_bundle(), model_bundle());
            end
            if (bus.tick === 1'b1) ticks++;
            if (bus.clock_out === 1'b1) highs++;
            if (bus.done === 1'b1) begin
                dones++;
                done_ok = prev_tick && (ticks == 3) && (bus.busy === 1'b0);
            end
            prev_tick = (bus.tick === 1'b1);
            step();
        end
        tests_run++;
        if (ticks !== 3 || highs !== 6 || dones !== 1 || done_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_summary: ticks %0d highs %0d dones %0d order %0d want 3 6 1 1",
                     ticks, highs, dones, done_ok);
        end
    endtask

    task automatic test_reconfig();
        go_idle();
        bus.start = 1; step(); bus.start = 0;
        step();
        bus.cfg_valid = 1; bus.cfg_divisor = 6; bus.cfg_burst = 0; step();
        bus.cfg_valid = 0;
        tests_run++;
        if (bus.cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reconfig_ready_c2: got %b want 0", bus.cfg_ready);
        end
        step();
        tests_run++;
        if ({bus.cfg_ready, bus.tick} !== 2'b01) begin
            tests_failed++;
            $display("FAIL reconfig_wrap: ready/tick got %b%b want 01", bus.cfg_ready, bus.tick);
        end
        step();
        for (int j = 0; j < 6; j++) begin
            tests_run++;
            if ({bus.clock_out, bus.tick, bus.cfg_ready} !== {(j < 3), (j == 5), 1'b1}) begin
                tests_failed++;
                $display("FAIL reconfig_d6_c%0d: clk/tick/ready got %b%b%b want %b%b1", j,
                         bus.clock_out, bus.tick, bus.cfg_ready, (j < 3), (j == 5));
            end
            tests_run++;
            if (dut_bundle() !== model_bundle()) begin
                tests_failed++;
                $display("FAIL reconfig_model c%0d: got %h want %h", j, dut_bundle(), model_bundle());
            end
            step();
        end
    endtask

    task automatic test_clamp();
        for (int d = 0; d < 2; d++) begin
            go_idle();
            bus.cfg_valid = 1; bus.cfg_divisor = CNT_W'(d); bus.cfg_burst = 0;
            bus.start = 1; step();
            idle_inputs();
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if ({bus.clock_out, bus.tick} !== {(i % 2 == 0), (i % 2 == 1)}) begin
                    tests_failed++;
                    $display("FAIL clamp_d%0d_c%0d: clk/tick got %b%b want %b%b", d, i,
                             bus.clock_out, bus.tick, (i % 2 == 0), (i % 2 == 1));
                end
                step();
            end
        end
    endtask

    task automatic test_stop();
        go_idle();
        bus.start = 1; step(); bus.start = 0;
        step();
        bus.stop = 1; step(); bus.stop = 0;
        tests_run++;
        if ({bus.busy, bus.tick} !== 2'b10) begin
            tests_failed++;
            $display("FAIL stop_c2: busy/tick got %b%b want 10", bus.busy, bus.tick);
        end
        step();
        tests_run++;
        if ({bus.busy, bus.tick} !== 2'b11) begin
            tests_failed++;
            $display("FAIL stop_c3: busy/tick got %b%b want 11", bus.busy, bus.tick);
        end
        step();
        tests_run++;
        if ({bus.busy, bus.done, bus.clock_out} !== 3'b000 || dut_bundle() !== model_bundle()) begin
            tests_failed++;
            $display("FAIL stop_idle: got %h want %h", dut_bundle(), model_bundle());
        end
    endtask

    task automatic test_reset_midburst();
        int dones = 0;
        go_idle();
        bus.cfg_valid = 1; bus.cfg_divisor = 3; bus.cfg_burst = 4;
        bus.start = 1; step();
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
        reset_n = 0; step(); reset_n = 1;
        tests_run++;
        if (dut_bundle() !== RESET_BUNDLE) begin
            tests_failed++;
            $display("FAIL reset_midburst: got %h want %h", dut_bundle(), RESET_BUNDLE);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done !== 1'b0) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d done cycles want 0", dones);
        end
        bus.start = 1; bus.stop = 1; step(); step();
        idle_inputs();
        tests_run++;
        if ({bus.busy, bus.clock_out} !== 2'b00) begin
            tests_failed++;
            $display("FAIL start_stop_together: busy/clk got %b%b want 00", bus.busy, bus.clock_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset_n         = ($urandom_range(0, 299) != 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.stop        = ($urandom_range(0, 39) == 0);
            bus.cfg_valid   = ($urandom_range(0, 5) == 0);
            bus.cfg_divisor = CNT_W'($urandom_range(0, 7));
            bus.cfg_burst   = BURST_W'($urandom_range(0, 4));
            step();
            tests_run++;
            if (dut_bundle() !== model_bundle()) begin
                tests_failed++;
                $display("FAIL random c%0d: got %h want %h", n, dut_bundle(), model_bundle());
            end
        end
        reset_n = 1;
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_continuous();
        test_burst();
        test_reconfig();
        test_clamp();
        test_stop();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
